// File: rtl/data_memory_arbiter_pkg.sv
// Shared constants, FSM state type and op encoding for the data memory arbiter.
`timescale 1ns/1ps
package data_memory_arbiter_pkg;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 8;
    localparam int N_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/data_memory_arbiter_rr.sv
// Round-robin grant generator: the port after the last granted one has top priority.
`timescale 1ns/1ps
module mem_rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clock,
    input  logic         clear,
    input  logic [N-1:0] i_valid,
    input  logic         i_advance,
    output logic [N-1:0] o_grant
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] w_grant_idx;
    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    always_comb begin
        o_grant     = '0;
        w_grant_idx = r_last;
        w_found     = 1'b0;
        w_cand      = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = IDX_W'((int'(r_last) + k) % N);
            if (!w_found && i_valid[w_cand]) begin
                o_grant[w_cand] = 1'b1;
                w_grant_idx     = w_cand;
                w_found         = 1'b1;
            end
        end
    end

    // Reset points at the highest port so port 0 wins the first contest.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_last <= IDX_W'(N - 1);
        end else if (i_advance && w_found) begin
            r_last <= w_grant_idx;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-port data memory between the CPU (port 0) and debug/loader (port 1).
// state  | meaning
// IDLE   | arbitrate, accept one request
// ACCESS | drive memory strobes for the latched op
// DONE   | pulse rsp valid to the owner
`timescale 1ns/1ps
module data_memory_arbiter #(
    parameter int ADDR_W = data_memory_arbiter_pkg::ADDR_W,
    parameter int DATA_W = data_memory_arbiter_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    import data_memory_arbiter_pkg::*;

    state_t              r_state;
    logic                r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_owner;
    logic                r_mem_read;
    logic                r_mem_write;
    logic                r_rsp0_valid;
    logic                r_rsp1_valid;
    logic [DATA_W-1:0]   r_rsp0_rdata;
    logic [DATA_W-1:0]   r_rsp1_rdata;

    logic [1:0]          w_valid;
    logic [1:0]          w_grant;
    logic                w_idle;
    logic                w_accept;
    logic                w_sel_port;
    logic                w_sel_op;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    assign w_valid  = {req1_valid, req0_valid};
    assign w_idle   = (r_state == IDLE);
    assign w_accept = w_idle && (|w_valid);

    mem_rr_arbiter #(
        .N (N_PORTS)
    ) u_rr (
        .clock     (clock),
        .clear     (clear),
        .i_valid   (w_valid),
        .i_advance (w_accept),
        .o_grant   (w_grant)
    );

    assign w_sel_port  = w_grant[1];
    assign w_sel_op    = w_sel_port ? req1_write : req0_write;
    assign w_sel_addr  = w_sel_port ? req1_addr  : req0_addr;
    assign w_sel_wdata = w_sel_port ? req1_wdata : req0_wdata;

    assign req0_ready  = w_idle && w_grant[0];
    assign req1_ready  = w_idle && w_grant[1];

    // Strobes are registered so the async clear drops them without a clock edge.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state      <= IDLE;
            r_op         <= OP_READ;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_owner      <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_rdata <= '0;
            r_rsp1_rdata <= '0;
        end else begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op        <= w_sel_op;
                        r_addr      <= w_sel_addr;
                        r_wdata     <= w_sel_wdata;
                        r_owner     <= w_sel_port;
                        r_mem_write <= (w_sel_op == OP_WRITE);
                        r_mem_read  <= (w_sel_op == OP_READ);
                        r_state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    if (r_op == OP_READ) begin
                        if (r_owner) r_rsp1_rdata <= mem_rdata;
                        else         r_rsp0_rdata <= mem_rdata;
                    end
                    if (r_owner) r_rsp1_valid <= 1'b1;
                    else         r_rsp0_valid <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_address = r_addr;
    assign mem_wdata   = r_wdata;
    assign rsp0_valid  = r_rsp0_valid;
    assign rsp1_valid  = r_rsp1_valid;
    assign rsp0_rdata  = r_rsp0_rdata;
    assign rsp1_rdata  = r_rsp1_rdata;
    assign busy        = !w_idle;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter with a behavioural memory and reference model.
`timescale 1ns/1ps
module tb_data_memory_arbiter;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          clear = 1'b1;
    logic [1:0]    vld;
    logic [1:0]    wr;
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          mem_read, mem_write, busy;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clock = ~clock;

    data_memory_arbiter dut (
        .clock       (clock),
        .clear       (clear),
        .req0_valid  (vld[0]),
        .req0_write  (wr[0]),
        .req0_addr   (ad[0]),
        .req0_wdata  (wd[0]),
        .req0_ready  (req0_ready),
        .rsp0_valid  (rsp0_valid),
        .rsp0_rdata  (rsp0_rdata),
        .req1_valid  (vld[1]),
        .req1_write  (wr[1]),
        .req1_addr   (ad[1]),
        .req1_wdata  (wd[1]),
        .req1_ready  (req1_ready),
        .rsp1_valid  (rsp1_valid),
        .rsp1_rdata  (rsp1_rdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    function automatic logic [7:0] pre(int a);
        case (a)
            3:       return 8'h03;
            17:      return 8'hFF;
            20:      return 8'hFC;
            default: return 8'(a * 37 + 11);
        endcase
    endfunction

    // Behavioural single-port memory.
    logic [7:0] mem [32];
    logic       do_preload = 1'b0;
    always @(posedge clock) begin
        if (do_preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= pre(i);
        end else if (mem_write) begin
            mem[mem_address] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_address];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state.
    typedef struct {
        int         port;
        logic [7:0] rdata;
        int         due;
    } exp_t;

    logic [7:0] shadow [32];
    logic [7:0] last_rd [2];
    int         m_last;
    bit         m_acc_valid;
    int         m_acc_cyc;
    bit         m_acc_write;
    logic [4:0] m_acc_addr;
    logic [7:0] m_acc_wdata;
    exp_t       q[$];
    int         grant_log[$];
    int         acc_cnt [2];
    int         rsp_cnt [2];
    bit         acc_last [2];

    // Arbitration, strobe and busy model; pushes expected responses.
    always @(negedge clock) begin
        bit   in_acc, in_done, free, g0, g1;
        int   p;
        exp_t e;
        if (!clear) begin
            m_last      = 1;
            m_acc_valid = 0;
            q.delete();
            last_rd[0]  = '0;
            last_rd[1]  = '0;
            acc_last    = '{0, 0};
            if (vld == 2'b00) begin
                check("rst_busy", busy, 0);
                check("rst_mem_rw", {mem_read, mem_write}, 0);
                check("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
                check("rst_ready", {req0_ready, req1_ready}, 0);
                check("rst_rdata", {rsp0_rdata, rsp1_rdata}, 0);
            end
        end else begin
            in_acc  = m_acc_valid && (cyc == m_acc_cyc + 1);
            in_done = m_acc_valid && (cyc == m_acc_cyc + 2);
            check("busy", busy, in_acc || in_done);
            check("mem_read", mem_read, in_acc && !m_acc_write);
            check("mem_write", mem_write, in_acc && m_acc_write);
            if (in_acc) check("mem_address", mem_address, m_acc_addr);
            if (in_acc && m_acc_write) check("mem_wdata", mem_wdata, m_acc_wdata);
            if (in_done && m_acc_write) shadow[m_acc_addr] = m_acc_wdata;
            free = !(in_acc || in_done);
            g0 = free && vld[0] && (!vld[1] || m_last == 1);
            g1 = free && vld[1] && (!vld[0] || m_last == 0);
            if (vld != 2'b00) begin
                check("ready0", req0_ready, g0);
                check("ready1", req1_ready, g1);
            end
            acc_last[0] = req0_ready && vld[0];
            acc_last[1] = req1_ready && vld[1];
            if (acc_last[0]) begin acc_cnt[0]++; grant_log.push_back(0); end
            if (acc_last[1]) begin acc_cnt[1]++; grant_log.push_back(1); end
            if (g0 || g1) begin
                p           = g1 ? 1 : 0;
                m_last      = p;
                m_acc_valid = 1;
                m_acc_cyc   = cyc;
                m_acc_write = wr[p];
                m_acc_addr  = ad[p];
                m_acc_wdata = wd[p];
                if (!wr[p]) last_rd[p] = shadow[ad[p]];
                e.port  = p;
                e.rdata = last_rd[p];
                e.due   = cyc + 2;
                q.push_back(e);
            end
        end
    end

    // Response monitor.
    always @(negedge clock) begin
        int   p;
        exp_t e;
        if (clear && (rsp0_valid || rsp1_valid)) begin
            p = rsp1_valid ? 1 : 0;
            rsp_cnt[p]++;
            check("rsp_one_port", rsp0_valid && rsp1_valid, 0);
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got response on port %0d expected none", p);
            end else begin
                e = q.pop_front();
                check("rsp_port", p, e.port);
                check("rsp_rdata", (p == 1) ? rsp1_rdata : rsp0_rdata, e.rdata);
                check("rsp_time", cyc, e.due);
            end
        end
    end

    task automatic set_req(int p, bit v, bit w, logic [4:0] a, logic [7:0] d);
        vld[p] = v;
        wr[p]  = w;
        ad[p]  = a;
        wd[p]  = d;
    endtask

    task automatic do_req(int p, bit w, logic [4:0] a, logic [7:0] d);
        bit got;
        got = 0;
        set_req(p, 1'b1, w, a, d);
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            got = (p == 0) ? req0_ready : req1_ready;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL req_timeout: port %0d ready=0 expected 1", p);
        end
        @(posedge clock);
        #1;
        vld[p] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while ((busy || q.size() != 0) && n < 40);
        if (n >= 40) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy=%0d pending=%0d expected 0", busy, q.size());
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        clear = 1'b0;
        @(negedge clock);
        #2;
        clear = 1'b1;
        @(posedge clock);
        #1;
    endtask

    int snap;

    initial begin
        vld = '0;
        wr  = '0;
        ad  = '{5'd0, 5'd0};
        wd  = '{8'd0, 8'd0};
        acc_cnt = '{0, 0};
        rsp_cnt = '{0, 0};
        for (int i = 0; i < 32; i++) shadow[i] = pre(i);
        #1 clear = 1'b0;
        do_preload = 1'b1;
        @(posedge clock);
        #1 do_preload = 1'b0;
        @(negedge clock);
        @(posedge clock);
        #1 clear = 1'b1;

        // 1: port 0 reads a preloaded word
        do_req(0, 1'b0, 5'd17, 8'h00);
        wait_idle();
        check("t1_rsp0_rdata", rsp0_rdata, 8'hFF);
        check("t1_rsp1_pulses", rsp_cnt[1], 0);
        check("t1_rsp1_rdata", rsp1_rdata, 8'h00);

        // 2: port 1 write then read back
        do_req(1, 1'b1, 5'd5, 8'hA5);
        wait_idle();
        do_req(1, 1'b0, 5'd5, 8'h00);
        wait_idle();
        repeat (3) @(posedge clock);
        #1;
        check("t2_rsp1_hold", rsp1_rdata, 8'hA5);

        // 3: both ports held from reset
        do_reset();
        grant_log.delete();
        set_req(0, 1'b1, 1'b0, 5'd3, 8'h00);
        set_req(1, 1'b1, 1'b0, 5'd20, 8'h00);
        repeat (12) @(posedge clock);
        #1;
        vld = '0;
        wait_idle();
        check("t3_grant_count", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size()) check("t3_grant_order", grant_log[i], i % 2);
        end
        check("t3_rsp0_rdata", rsp0_rdata, 8'h03);
        check("t3_rsp1_rdata", rsp1_rdata, 8'hFC);

        // 4: port 0 blips valid while port 1 is in ACCESS
        snap = acc_cnt[0];
        do_req(1, 1'b0, 5'd9, 8'h00);
        set_req(0, 1'b1, 1'b0, 5'd12, 8'h00);
        @(posedge clock);
        #1;
        vld[0] = 1'b0;
        wait_idle();
        check("t4_no_port0_accept", acc_cnt[0], snap);
        check("t4_rsp1_rdata", rsp1_rdata, pre(9));

        // 5: clear during ACCESS of a write
        do_req(0, 1'b1, 5'd3, 8'h55);
        check("t5_mem_write_before", mem_write, 1);
        clear = 1'b0;
        #1;
        check("t5_mem_write_async", mem_write, 0);
        check("t5_busy", busy, 0);
        check("t5_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        @(negedge clock);
        #2 clear = 1'b1;
        @(posedge clock);
        #1;
        check("t5_mem3_kept", mem[3], 8'h03);
        grant_log.delete();
        set_req(0, 1'b1, 1'b0, 5'd3, 8'h00);
        set_req(1, 1'b1, 1'b0, 5'd20, 8'h00);
        repeat (4) @(posedge clock);
        #1;
        vld = '0;
        wait_idle();
        if (grant_log.size() > 0) check("t5_first_grant", grant_log[0], 0);
        else check("t5_any_grant", grant_log.size(), 1);
        check("t5_rsp0_rdata", rsp0_rdata, 8'h03);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            @(posedge clock);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (!vld[p] || acc_last[p]) begin
                    set_req(p, ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                            5'($urandom_range(0, 31)), 8'($urandom));
                end else if ($urandom_range(0, 7) == 0) begin
                    vld[p] = 1'b0;
                end
            end
        end
        vld = '0;
        wait_idle();
        check("final_queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
Round-robin controller that shares the single-port 32x8 data memory between two requesters: port 0 is the CPU datapath and port 1 is the debug/loader port. It accepts one request at a time with a valid/ready handshake. It drives the memory's read strobe, write strobe, address and write data, and returns a registered response (read data plus valid pulse) to the requester that owns the transaction. It sits between the requesters and data_memory; it is the only driver of the memory control inputs.

Parameters:
ADDR_W, 5, memory address width (32 words).
DATA_W, 8, memory word width.

Ports:
clock  input  1  system clock, rising edge.
clear  input  1  asynchronous, active-low reset.
req0_valid  input  1  port 0 request present.
req0_write  input  1  port 0 operation: 1 = write, 0 = read.
req0_addr  input  ADDR_W  port 0 word address.
req0_wdata  input  DATA_W  port 0 write data.
req0_ready  output  1  port 0 request accepted this cycle.
rsp0_valid  output  1  port 0 transaction complete (1-cycle pulse).
rsp0_rdata  output  DATA_W  port 0 read data.
req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata: same as port 0, for port 1.
mem_read  output  1  to memory read strobe.
mem_write  output  1  to memory write strobe.
mem_address  output  ADDR_W  to memory address.
mem_wdata  output  DATA_W  to memory write data.
mem_rdata  input  DATA_W  combinational read data from memory.
busy  output  1  transaction in flight (state != IDLE).

Behaviour:
- Reset (clear low, asynchronous): state = IDLE; priority pointer favours port 0; all outputs 0; latched op/addr/wdata/owner/rdata = 0. The memory write strobe drops immediately, so an in-flight write is aborted.
- FSM IDLE -> ACCESS -> DONE -> IDLE. Each transaction takes 3 cycles; peak throughput is one transaction per 3 cycles.
- IDLE:
  - Arbitrate among asserted reqN_valid.
  - reqN_ready = IDLE && grantN. It is combinational from valid, and at most one ready is high.
  - On acceptance: latch write, addr, wdata and owner; move to ACCESS.
  - No valid: stay in IDLE.
- ACCESS:
  - mem_address = latched addr; mem_wdata = latched wdata.
  - mem_write = latched write; mem_read = !latched write.
  - A write commits at the closing clock edge.
  - A read latches mem_rdata into the response register at the closing edge.
  - Move to DONE.
- DONE:
  - rsp<owner>_valid = 1 for exactly one cycle.
  - rsp<owner>_rdata = captured data for reads. It holds its previous value for writes.
  - Move to IDLE.
- Outside ACCESS: mem_read = mem_write = 0, and mem_address/mem_wdata hold the latched values.
- rspN_rdata is held until that port's next read completes.
- Arbitration:
  - Single requester: it is granted.
  - Both valid: the port not granted last wins. The pointer updates only on acceptance.
  - Both valid immediately after reset: port 0 wins.
- Requester rules:
  - Hold valid and fields stable until ready. Fields are sampled only in the ready cycle.
  - Dropping valid before ready is legal and has no effect.
  - A requester may present a new request in the same cycle as its rsp_valid; it is considered in the following IDLE cycle.
- No starvation: with both ports continuously requesting, grants alternate 0,1,0,1.
- Full ADDR_W range 0..31 is legal; there is no out-of-range condition.
- The memory's own preload clear is driven separately and is not controlled here.

Decomposition:
- Shared package: ADDR_W/DATA_W constants, FSM state enum (IDLE, ACCESS, DONE), and the op encoding (OP_READ = 0, OP_WRITE = 1).
- One sub-module: mem_rr_arbiter.
  - Inputs: 2 valids and an advance strobe.
  - Outputs: one-hot grant.
  - Contains the last-grant pointer register.
  - Reusable for a later 4-port version.

Test Plan:
1. Memory preloaded; port 0 reads addr 17 -> req0_ready in cycle 0, mem_read high in cycle 1, rsp0_valid in cycle 2 with rsp0_rdata = 8'hFF; port 1 outputs stay 0.
2. Port 1 writes addr 5 with 8'hA5 -> mem_write high for exactly 1 cycle with mem_address = 5. A following port 1 read of addr 5 returns 8'hA5, and rsp1_rdata remains 8'hA5 afterwards.
3. Both ports valid from reset, reading addr 3 (port 0) and addr 20 (port 1), held continuously -> grant order 0,1,0,1. rsp0_rdata = 8'h03 and rsp1_rdata = 8'hFC. Responses are spaced 3 cycles apart.
4. Port 0 asserts valid for 1 cycle while a port 1 transaction is in ACCESS, then drops it -> no port 0 acceptance; port 1 completes normally.
5. clear driven low during ACCESS of a port 0 write (addr 3, 8'h55) -> mem_write falls without waiting for a clock edge. Memory word 3 stays 8'h03, busy = 0, no rsp pulse. The first request after release with both ports valid goes to port 0.
